seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider. It is the inverse operation of the team's combinational Wallace multipliers and completes the multdiv pair.
- Computes quotient and remainder one bit per clock using a restoring shift-subtract algorithm.
- Sits beside the multiplier in the multdiv unit and uses a simple start/done handshake toward the issuing controller.

---
 rtl/seq_div_pkg.sv | 29 ++
 rtl/div_step.sv | 41 ++++
 rtl/seq_restoring_divider.sv | 164 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   clog2()       : bits needed to hold a value range, used for the step counter
//   DIV0_QUOTIENT : quotient pattern reported on a divide by zero (all ones),
//                   sliced to the operand width by the user
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Divide by zero reports an all-ones quotient; the remainder is the dividend.
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  // Number of bits needed to encode 'value' distinct codes (0 .. value-1).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   rem_in  : partial remainder before the step (always < divisor)
//   quo_in  : working quotient register; its MSB is the next dividend bit
//   divisor : denominator magnitude
//   rem_out : partial remainder after shift and conditional subtract
//   quo_out : working quotient shifted left with the new quotient bit in bit 0
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // rem_in < divisor, so shifted < 2*divisor and the difference always lies
  // strictly between -2^WIDTH and 2^WIDTH: WIDTH+1 bits hold it exactly and
  // bit WIDTH is a valid sign bit.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign fits    = ~trial[WIDTH];

  // Per-bit restore mux: keep the difference when it is non-negative,
  // otherwise fall back to the shifted remainder.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sel
      assign rem_out[gi] = fits ? trial[gi] : shifted[gi];
    end
  endgenerate

  assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle integer divider, one quotient bit per clock (restoring algorithm).
// Companion of the combinational multiplier in the multdiv unit.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, accepted in IDLE or DONE only
//   dividend     numerator, sampled on acceptance
//   divisor      denominator, sampled on acceptance
//   busy         high while iterating (RUN)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  set together with done when the divisor was zero
//
// Build option: define SEQ_DIV_SIGNED_EN for two's complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it the unit is purely unsigned and no sign logic exists.
//
// Timing: the accepting edge is E0, steps run on E1..E_WIDTH, and done is
// high for the cycle after E_WIDTH. A zero divisor completes on E1.
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [CNT_W-1:0] count_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;
  logic             accept;
  logic             divisor_zero;

  assign accept       = start && (state_reg != RUN);
  assign divisor_zero = (divisor == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (divisor_reg),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_quo_reg;
  logic neg_rem_reg;

  // The iteration works on magnitudes; signs are re-applied on the way into
  // the output registers, so the latency matches the unsigned build. The
  // most-negative magnitude is still correct read as unsigned, and negating
  // a most-negative quotient wraps back to itself.
  assign dividend_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
  assign quo_final    = neg_quo_reg ? (~quo_next + WIDTH'(1)) : quo_next;
  assign rem_final    = neg_rem_reg ? (~rem_next + WIDTH'(1)) : rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (accept) begin
      neg_quo_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_reg <= dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign quo_final    = quo_next;
  assign rem_final    = rem_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      count_reg   <= '0;
      zero_reg    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            // A zero divisor still spends one cycle in RUN so its result
            // lands on E1; the raw dividend is parked in quo_reg so it can
            // be returned as the remainder in either signedness.
            divisor_reg <= divisor_mag;
            rem_reg     <= '0;
            quo_reg     <= divisor_zero ? dividend : dividend_mag;
            count_reg   <= divisor_zero ? CNT_ONE : CNT_FULL;
            zero_reg    <= divisor_zero;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          if (zero_reg) begin
            quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
            remainder   <= quo_reg;
            div_by_zero <= 1'b1;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_reg   <= DONE;
          end else begin
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            count_reg <= count_reg - CNT_ONE;
            if (count_reg == CNT_ONE) begin
              quotient  <= quo_final;
              remainder <= rem_final;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8). Stimulus pushes the
// hand-computed result of every accepted request; a monitor on the falling
// edge pops and compares whenever done is seen.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [W-1:0] Q_200_3  = 8'hEE, R_200_3  = 8'hFE;  // -56/3
  localparam logic [W-1:0] Q_254_17 = 8'h00, R_254_17 = 8'hFE;  // -2/17
  localparam logic [W-1:0] Q_255_2  = 8'h00, R_255_2  = 8'hFF;  // -1/2
`else
  localparam logic [W-1:0] Q_200_3  = 8'd66,  R_200_3  = 8'd2;
  localparam logic [W-1:0] Q_254_17 = 8'd14,  R_254_17 = 8'd16;
  localparam logic [W-1:0] Q_255_2  = 8'd127, R_255_2  = 8'd1;
`endif

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
    int           busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles and checks each completion against the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 required no pending request");
        end else begin
          e = sb.pop_front();
          chk({e.name, " quotient"}, 32'(quotient), 32'(e.q));
          chk({e.name, " remainder"}, 32'(remainder), 32'(e.r));
          chk({e.name, " div_by_zero"}, 32'(div_by_zero), 32'(e.z));
          chk({e.name, " done_cycle"}, 32'(cyc), 32'(e.cyc));
          chk({e.name, " busy_cycles"}, 32'(busy_cnt), 32'(e.busy_cycles));
          $display("[TB] %s -> q=%02h r=%02h dz=%0b at cycle %0d",
                   e.name, quotient, remainder, div_by_zero, cyc);
        end
      end
    end
  end

  // Drive a request in the current cycle; it is accepted on the next edge.
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = 0;
    e.name        = name;
    e.q           = q;
    e.r           = r;
    e.z           = z;
    e.busy_cycles = z ? 1 : W;
    e.cyc         = cyc + e.busy_cycles;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || done) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy || done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got busy=%0b done=%0b required idle", name, busy, done);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got done=0 required done=1", name);
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " done"}, 32'(done), 32'd0);
    chk({name, " div_by_zero"}, 32'(div_by_zero), 32'd0);
    chk({name, " quotient"}, 32'(quotient), 32'd0);
    chk({name, " remainder"}, 32'(remainder), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    wait_idle("100/7");

    issue("55/0", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1);
    wait_idle("55/0");

    // A request during RUN must be ignored.
    issue("200/3", 8'd200, 8'd3, Q_200_3, R_200_3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("200/3");
    repeat (3) @(posedge clk);
    #1;
    chk("hold quotient", 32'(quotient), 32'(Q_200_3));
    chk("hold remainder", 32'(remainder), 32'(R_200_3));

    // Asynchronous reset in the middle of a division.
    issue("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    sb.delete(sb.size() - 1);
    $display("[TB] 255/1 aborted by reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    wait_idle("5/9");

    // Back-to-back: second request driven during the done cycle.
    issue("77/5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
    wait_done("77/5");
    issue("12/4", 8'd12, 8'd4, 8'd3, 8'd0, 1'b0);
    wait_idle("12/4");

    issue("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    wait_idle("255/255");
    issue("254/17", 8'd254, 8'd17, Q_254_17, R_254_17, 1'b0);
    wait_idle("254/17");
    issue("255/2", 8'd255, 8'd2, Q_255_2, R_255_2, 1'b0);
    wait_idle("255/2");
    issue("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    wait_idle("0/5");
    issue("1/200", 8'd1, 8'd200, 8'd0, 8'd1, 1'b0);
    wait_idle("1/200");

`ifdef SEQ_DIV_SIGNED_EN
    issue("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    wait_idle("-100/7");
    issue("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    wait_idle("-128/-1");
`endif

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
